// File: rtl/msu_pkg.sv
// Shared MSU definitions: reduction-tree defaults, beat sideband type and
// helpers that size the pipelined column-sum tree.
package msu_pkg;

    localparam int unsigned RedTreeLevelsPerStage = 2;
    localparam int unsigned RedAccGuardBits       = 8;

    typedef struct packed {
        logic acc;
        logic last;
    } red_sum_side_t;

    // Nodes left after halving n a given number of times; odd leftovers survive.
    function automatic int unsigned red_tree_nodes(int unsigned n, int unsigned levels);
        int unsigned c;
        c = n;
        for (int unsigned k = 0; k < levels; k++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    function automatic int unsigned red_tree_stages(int unsigned num_terms,
                                                    int unsigned levels_per_stage);
        if (num_terms <= 1) begin
            return 0;
        end
        return (int'($clog2(num_terms)) + levels_per_stage - 1) / levels_per_stage;
    endfunction

endpackage

// File: rtl/red_sum_tree_stage.sv
// Combinational slice of the adder tree: NumLevels pairwise-add levels over
// a node array; an odd last node at any level passes through unchanged.
module red_sum_tree_stage
    import msu_pkg::*;
#(
    parameter  int unsigned InNodes   = 2,
    parameter  int unsigned NodeBits  = 8,
    parameter  int unsigned NumLevels = 1,
    localparam int unsigned OutNodes  = red_tree_nodes(InNodes, NumLevels)
) (
    input  logic [NodeBits-1:0] in_nodes  [InNodes],
    output logic [NodeBits-1:0] out_nodes [OutNodes]
);

    // One spare column keeps the pair index in range for odd node counts.
    logic [NodeBits-1:0] lvl [NumLevels+1][InNodes+1];

    always_comb begin
        int unsigned cnt;
        lvl = '{default: '0};
        cnt = InNodes;
        for (int unsigned i = 0; i < InNodes; i++) begin
            lvl[0][i] = in_nodes[i];
        end
        for (int unsigned k = 0; k < NumLevels; k++) begin
            for (int unsigned j = 0; j < (InNodes + 1) / 2; j++) begin
                if (2 * j + 1 < cnt) begin
                    lvl[k+1][j] = lvl[k][2*j] + lvl[k][2*j+1];
                end else if (2 * j < cnt) begin
                    lvl[k+1][j] = lvl[k][2*j];
                end
            end
            cnt = (cnt + 1) / 2;
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < OutNodes; j++) begin
            out_nodes[j] = lvl[NumLevels][j];
        end
    end

endmodule

// File: rtl/red_sum_tree_pipe.sv
// Pipelined column summer: registered adder tree with global-stall flow
// control and an optional per-frame accumulator in the output stage.
module red_sum_tree_pipe
    import msu_pkg::*;
#(
    parameter int unsigned NumTerms       = 16,
    parameter int unsigned TermBits       = 32,
    parameter int unsigned LevelsPerStage = RedTreeLevelsPerStage,
    parameter int unsigned AccGuardBits   = RedAccGuardBits,
    parameter int unsigned SumBits        = TermBits + $clog2(NumTerms) + AccGuardBits
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [TermBits-1:0] in_terms_i [NumTerms],
    input  logic                in_acc_i,
    input  logic                in_last_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [SumBits-1:0]  out_sum_o,
    output logic                out_ovf_o
);

    localparam int unsigned Levels   = $clog2(NumTerms);
    localparam int unsigned P        = red_tree_stages(NumTerms, LevelsPerStage);
    localparam int unsigned TreeBits = TermBits + Levels;

    typedef logic [TreeBits-1:0] node_t;

    if (SumBits < TermBits + Levels) begin : g_bad_width
        $error("red_sum_tree_pipe: SumBits too narrow for an exact tree result");
    end

    logic advance;
    assign advance    = ~out_valid_o | out_ready_i;
    assign in_ready_o = advance & ~rst_i;

    // feed_* index s is the input to tree stage s; index P feeds the output stage.
    node_t         feed_data  [P+1][NumTerms];
    logic          feed_valid [P+1];
    red_sum_side_t feed_side  [P+1];

    for (genvar i = 0; i < NumTerms; i++) begin : g_feed0
        assign feed_data[0][i] = TreeBits'(in_terms_i[i]);
    end
    assign feed_valid[0] = in_valid_i & in_ready_o;
    assign feed_side[0]  = '{acc: in_acc_i, last: in_last_i};

    for (genvar s = 0; s < P; s++) begin : g_stage
        localparam int unsigned FirstLvl = s * LevelsPerStage;
        localparam int unsigned StLevels = (Levels - FirstLvl < LevelsPerStage) ?
                                           (Levels - FirstLvl) : LevelsPerStage;
        localparam int unsigned InCnt    = red_tree_nodes(NumTerms, FirstLvl);
        localparam int unsigned OutCnt   = red_tree_nodes(NumTerms, FirstLvl + StLevels);

        node_t         st_in  [InCnt];
        node_t         st_out [OutCnt];
        node_t         q_data [OutCnt];
        logic          q_valid;
        red_sum_side_t q_side;

        for (genvar i = 0; i < InCnt; i++) begin : g_in
            assign st_in[i] = feed_data[s][i];
        end

        red_sum_tree_stage #(
            .InNodes  (InCnt),
            .NodeBits (TreeBits),
            .NumLevels(StLevels)
        ) u_stage (
            .in_nodes (st_in),
            .out_nodes(st_out)
        );

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                q_valid <= 1'b0;
            end else if (advance) begin
                q_valid <= feed_valid[s];
            end
        end

        always_ff @(posedge clk_i) begin
            if (advance) begin
                q_side <= feed_side[s];
                q_data <= st_out;
            end
        end

        for (genvar i = 0; i < NumTerms; i++) begin : g_out
            if (i < OutCnt) begin : g_live
                assign feed_data[s+1][i] = q_data[i];
            end else begin : g_zero
                assign feed_data[s+1][i] = '0;
            end
        end
        assign feed_valid[s+1] = q_valid;
        assign feed_side[s+1]  = q_side;
    end

    logic [SumBits-1:0] acc;
    logic               sticky;
    logic [SumBits-1:0] tree_ext;
    logic [SumBits:0]   acc_next;

    assign tree_ext = SumBits'(feed_data[P][0]);
    assign acc_next = {1'b0, acc} + {1'b0, tree_ext};

    // Pass beats leave acc/sticky alone so they can sit inside an open frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_sum_o   <= '0;
            out_ovf_o   <= 1'b0;
            acc         <= '0;
            sticky      <= 1'b0;
        end else if (advance) begin
            out_valid_o <= 1'b0;
            if (feed_valid[P]) begin
                if (!feed_side[P].acc) begin
                    out_valid_o <= 1'b1;
                    out_sum_o   <= tree_ext;
                    out_ovf_o   <= 1'b0;
                end else if (!feed_side[P].last) begin
                    acc    <= acc_next[SumBits-1:0];
                    sticky <= sticky | acc_next[SumBits];
                end else begin
                    out_valid_o <= 1'b1;
                    out_sum_o   <= acc_next[SumBits-1:0];
                    out_ovf_o   <= sticky | acc_next[SumBits];
                    acc         <= '0;
                    sticky      <= 1'b0;
                end
            end
        end
    end

    logic [NumTerms*TermBits-1:0] terms_flat;
    always_comb begin
        terms_flat = '0;
        for (int unsigned i = 0; i < NumTerms; i++) begin
            terms_flat[i*TermBits +: TermBits] = in_terms_i[i];
        end
    end

    a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (in_valid_i && !in_ready_o) |=> $stable({terms_flat, in_acc_i, in_last_i}));

endmodule

// File: tb/tb_red_sum_tree_pipe.sv
// Self-checking bench for red_sum_tree_pipe (4 x 8-bit terms, 1 level/stage).
module tb_red_sum_tree_pipe;

    localparam int NT = 4;
    localparam int TB = 8;
    localparam int SB = 12;

    typedef struct packed {
        logic                   acc;
        logic                   last;
        logic [NT-1:0][TB-1:0]  t;
    } beat_t;

    typedef struct packed {
        logic          ovf;
        logic [SB-1:0] sum;
    } res_t;

    typedef struct packed {
        logic [31:0]   cyc;
        logic          ovf;
        logic [SB-1:0] sum;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TB-1:0] in_terms [NT];
    logic          in_acc;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [SB-1:0] out_sum;
    logic          out_ovf;

    always #5 clk = ~clk;

    red_sum_tree_pipe #(
        .NumTerms      (NT),
        .TermBits      (TB),
        .LevelsPerStage(1),
        .AccGuardBits  (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_terms_i (in_terms),
        .in_acc_i   (in_acc),
        .in_last_i  (in_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_sum_o  (out_sum),
        .out_ovf_o  (out_ovf)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit rand_gaps  = 0;
    bit rand_ready = 0;

    beat_t pend [$];
    res_t  exp_q [$];
    obs_t  obs [$];
    longint unsigned frame_total = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Reference: frame total kept as an unbounded integer, wrapped only on output.
    task automatic model_accept(beat_t b);
        longint unsigned s;
        res_t r;
        s = 0;
        for (int i = 0; i < NT; i++) s += b.t[i];
        if (!b.acc) begin
            r.ovf = 1'b0;
            r.sum = s[SB-1:0];
            exp_q.push_back(r);
        end else begin
            frame_total += s;
            if (b.last) begin
                r.ovf = (frame_total >= (64'd1 << SB));
                r.sum = frame_total[SB-1:0];
                exp_q.push_back(r);
                frame_total = 0;
            end
        end
    endtask

    task automatic present(bit took_prev);
        bit hold;
        hold = in_valid && !took_prev;
        if (pend.size() != 0 && (hold || !rand_gaps || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            in_acc   = pend[0].acc;
            in_last  = pend[0].last;
            for (int i = 0; i < NT; i++) in_terms[i] = pend[0].t[i];
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic tick();
        bit   took;
        res_t e;
        obs_t o;
        took = 1'b0;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            frame_total = 0;
        end else begin
            if (out_valid && out_ready) begin
                o.cyc = cyc;
                o.ovf = out_ovf;
                o.sum = out_sum;
                obs.push_back(o);
                check("sb_result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_sum", 32'(out_sum), 32'(e.sum));
                    check("sb_ovf", 32'(out_ovf), 32'(e.ovf));
                end
            end
            if (in_valid && in_ready) begin
                model_accept(pend.pop_front());
                took = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
        present(took);
    endtask

    function automatic beat_t mk(logic acc, logic last, int a, int b, int c, int d);
        beat_t r;
        r.acc  = acc;
        r.last = last;
        r.t[0] = TB'(a);
        r.t[1] = TB'(b);
        r.t[2] = TB'(c);
        r.t[3] = TB'(d);
        return r;
    endfunction

    task automatic push_four();
        pend.push_back(mk(0, 0, 1, 2, 3, 4));
        pend.push_back(mk(0, 0, 5, 5, 5, 5));
        pend.push_back(mk(0, 0, 0, 10, 10, 10));
        pend.push_back(mk(0, 0, 10, 10, 10, 10));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int sums [4];
        beat_t b;
        sums = '{10, 20, 30, 40};

        rst = 1'b1; in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < NT; i++) in_terms[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 1: single pass beat, latency 3
        obs.delete();
        pend.push_back(mk(0, 0, 'hFF, 'hFF, 'hFF, 'hFF));
        present(1'b0);
        c0 = cyc;
        tick(); check("t1_valid_c1", 32'(out_valid), 32'd0);
        tick(); check("t1_valid_c2", 32'(out_valid), 32'd0);
        tick(); check("t1_valid_c3", 32'(out_valid), 32'd1);
        check("t1_sum", 32'(out_sum), 32'h3FC);
        check("t1_ovf", 32'(out_ovf), 32'd0);
        tick();
        check("t1_count", obs.size(), 32'd1);
        if (obs.size() == 1) check("t1_cycle", obs[0].cyc, 32'(c0 + 3));

        // 2: back-to-back pass beats
        obs.delete();
        push_four();
        present(1'b0);
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            check("t2_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        repeat (4) tick();
        check("t2_count", obs.size(), 32'd4);
        for (int k = 0; k < 4 && k < obs.size(); k++) begin
            check("t2_sum", 32'(obs[k].sum), 32'(sums[k]));
            check("t2_cycle", obs[k].cyc, 32'(c0 + 3 + k));
        end

        // 3: downstream stall of 5 cycles
        obs.delete();
        push_four();
        present(1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("t3_first_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        repeat (5) begin
            #1;
            check("t3_in_ready_low", 32'(in_ready), 32'd0);
            check("t3_sum_held", 32'(out_sum), 32'd10);
            check("t3_valid_held", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        repeat (10) tick();
        check("t3_count", obs.size(), 32'd4);
        for (int k = 0; k < 4 && k < obs.size(); k++) check("t3_sum", 32'(obs[k].sum), 32'(sums[k]));

        // 4: 3-beat frame then a zero pass beat
        obs.delete();
        pend.push_back(mk(1, 0, 1, 2, 3, 4));
        pend.push_back(mk(1, 0, 1, 2, 3, 4));
        pend.push_back(mk(1, 1, 1, 2, 3, 4));
        pend.push_back(mk(0, 0, 0, 0, 0, 0));
        present(1'b0);
        repeat (12) tick();
        check("t4_count", obs.size(), 32'd2);
        if (obs.size() == 2) begin
            check("t4_frame_sum", 32'(obs[0].sum), 32'd30);
            check("t4_frame_ovf", 32'(obs[0].ovf), 32'd0);
            check("t4_pass_sum", 32'(obs[1].sum), 32'd0);
        end

        // 5: overflowing frame, then a fresh frame
        obs.delete();
        for (int k = 0; k < 5; k++) pend.push_back(mk(1, k == 4, 'hFF, 'hFF, 'hFF, 'hFF));
        pend.push_back(mk(1, 1, 1, 0, 0, 0));
        present(1'b0);
        repeat (14) tick();
        check("t5_count", obs.size(), 32'd2);
        if (obs.size() == 2) begin
            check("t5_wrap_sum", 32'(obs[0].sum), 32'd1004);
            check("t5_wrap_ovf", 32'(obs[0].ovf), 32'd1);
            check("t5_next_sum", 32'(obs[1].sum), 32'd1);
            check("t5_next_ovf", 32'(obs[1].ovf), 32'd0);
        end

        // 6: reset with work in flight
        obs.delete();
        pend.push_back(mk(1, 0, 'hFF, 'hFF, 'hFF, 'hFF));
        pend.push_back(mk(1, 0, 'hFF, 'hFF, 'hFF, 'hFF));
        pend.push_back(mk(0, 0, 2, 2, 2, 2));
        pend.push_back(mk(0, 0, 2, 2, 2, 2));
        present(1'b0);
        repeat (3) tick();
        rst = 1'b1;
        pend.delete();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("t6_valid_after_rst", 32'(out_valid), 32'd0);
        check("t6_ready_after_rst", 32'(in_ready), 32'd1);
        pend.push_back(mk(1, 1, 1, 1, 1, 1));
        present(1'b0);
        repeat (6) tick();
        check("t6_count", obs.size(), 32'd1);
        if (obs.size() == 1) begin
            check("t6_sum", 32'(obs[0].sum), 32'd4);
            check("t6_ovf", 32'(obs[0].ovf), 32'd0);
        end

        // Random traffic against the reference model
        rand_gaps  = 1'b1;
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            b.acc  = ($urandom_range(0, 9) < 6);
            b.last = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < NT; i++) b.t[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : TB'($urandom);
            pend.push_back(b);
        end
        for (int i = 0; i < 20000 && (pend.size() != 0 || exp_q.size() != 0); i++) tick();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (5) tick();
        check("rand_beats_drained", pend.size(), 32'd0);
        check("rand_results_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/red_sum_tree_pipe.md
Name: red_sum_tree_pipe

Overview:
Parametrised, pipelined successor to the reduction-grid column summer. It sums NumTerms unsigned terms per beat through a binary adder tree with a register slice every LevelsPerStage levels and valid/ready flow control. An optional accumulate mode sums tree results across the beats of a frame and emits one result per frame. It sits between the reduction grid rows and the carry-save/normalisation logic of the MSU.

Parameters:
NumTerms, 16, number of terms per beat (>=1).
TermBits, 32, width of each unsigned term.
LevelsPerStage, 2, adder-tree levels between pipeline registers (>=1).
AccGuardBits, 8, extra accumulator headroom bits.
SumBits, TermBits+$clog2(NumTerms)+AccGuardBits, width of the output and the accumulator.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
in_valid_i  in  1  input beat valid
in_ready_o  out  1  block accepts a beat this cycle
in_terms_i  in  NumTerms x TermBits  unpacked term array
in_acc_i  in  1  beat belongs to an accumulate frame
in_last_i  in  1  final beat of an accumulate frame (ignored when in_acc_i=0)
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts the result
out_sum_o  out  SumBits  result
out_ovf_o  out  1  a carry was lost beyond SumBits for this result

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Reset: out_valid_o=0, out_sum_o=0, out_ovf_o=0, accumulator=0, overflow sticky=0, and all stage valid bits=0. in_ready_o=0 while rst_i=1.
- Tree:
  - Levels = $clog2(NumTerms).
  - Internal register slices P = ceil(Levels/LevelsPerStage), or 0 when NumTerms=1.
  - Odd leftover nodes at a level pass through unchanged.
  - Each node is zero-extended, so the tree result is exact in TermBits+Levels bits.
- Latency: P+1 cycles from an accepted beat to out_valid_o, with no stall.
- Flow control:
  - Global stall: advance = ~out_valid_o | out_ready_i.
  - in_ready_o = advance & ~rst_i.
  - A beat is accepted when in_valid_i & in_ready_o.
  - Every slice and its valid bit load only when advance=1. Bubbles travel with the data and are not collapsed.
  - While stalled, out_sum_o and out_ovf_o are held stable.
- Sideband: in_acc_i and in_last_i travel with the data through every slice.
- Final stage (output register), when a valid tree result S arrives and advance=1:
  - Pass beat (acc=0): out_sum_o=S zero-extended, out_ovf_o=0, out_valid_o=1. The accumulator and sticky are untouched, so a pass beat may be interleaved inside a frame.
  - Accumulate, not last: acc <= acc+S mod 2^SumBits. sticky |= carry-out. No output; out_valid_o <= 0.
  - Accumulate, last: out_sum_o = acc+S mod 2^SumBits. out_ovf_o = sticky | carry-out. out_valid_o=1. acc <= 0, sticky <= 0.
  - No valid tree result and advance=1: out_valid_o <= 0.
- Wrap: all arithmetic is modulo 2^SumBits. Overflow is reported, never saturated.
- Reset mid-operation: all in-flight beats and any partial frame are discarded. A new frame starts from acc=0.
- Assertions:
  - in_terms_i, in_acc_i and in_last_i must stay stable while in_valid_i & ~in_ready_o.
  - Elaboration check: SumBits >= TermBits+Levels.

Decomposition:
- msu_pkg gains:
  - RedTreeLevelsPerStage and RedAccGuardBits constants.
  - A red_sum_side_t struct {acc, last}.
  - A function red_tree_stages(NumTerms, LevelsPerStage) returning P.
- One sub-module, red_sum_tree_stage. It implements LevelsPerStage combinational levels on an input node array and outputs the narrower node array. The top instantiates it P times and registers between instances.
- The accumulator and output register stay in the top.

Test Plan:
Config for all scenarios: NumTerms=4, TermBits=8, LevelsPerStage=1, AccGuardBits=2, so SumBits=12, P=2 and latency=3.
1. One pass beat of terms {FF,FF,FF,FF}, out_ready_i=1 -> out_valid_o in cycle 3 after acceptance, out_sum_o=0x3FC, out_ovf_o=0.
2. Four back-to-back pass beats with sums 10,20,30,40, out_ready_i=1 -> results 10,20,30,40 in consecutive cycles 3..6, and in_ready_o stays 1.
3. Scenario 2 with out_ready_i=0 for 5 cycles once the first result is valid -> in_ready_o=0 and out_sum_o held at 10 for those cycles, then all four results delivered in order with none lost.
4. Accumulate frame of 3 beats {1,2,3,4}, in_last_i on beat 3, then one pass beat of {0,0,0,0} -> a single result 30 (ovf=0), then a result of 0. No output for beats 1-2.
5. Accumulate frame of 5 beats of {FF,FF,FF,FF}, each beat summing to 1020, last on beat 5 -> out_sum_o=1004 (5100 mod 4096), out_ovf_o=1. The next frame of 1 beat {1,0,0,0} -> 1 with ovf=0.
6. rst_i pulsed for 1 cycle with the pipe full and 2 accumulate beats pending -> next cycle out_valid_o=0 and in_ready_o=1. A following 1-beat frame {1,1,1,1} with last -> 4.
